stacked_program_sequencer: RTL and testbench
============================================

Name: stacked_program_sequencer

Overview:
Parametrised next-generation program sequencer for the micro core. It generates the program-memory address each cycle from reset, hold, return, call, unconditional jump and conditional jump requests issued by the instruction decoder. It adds a hardware call/return stack of configurable depth and a PC of configurable width. It sits between the instruction decoder / computational unit and program memory; program memory is clocked on the falling edge of clk.

Parameters:
PC_WIDTH, 10, width of pc, pm_address, jmp_addr and stack entries
STACK_DEPTH, 4, number of return-address entries (legal range 1..16)
SP_WIDTH, 3, width of sp output; must satisfy 2^SP_WIDTH > STACK_DEPTH

Ports:
clk  in  1  system clock, rising-edge state update
reset  in  1  asynchronous, active-low reset
hold  in  1  stall; PC and stack frozen, same address re-presented
jmp  in  1  unconditional jump to jmp_addr
jmp_nz  in  1  conditional jump to jmp_addr, taken only when dont_jmp=0
dont_jmp  in  1  zero flag from computational unit
call  in  1  push return address, jump to jmp_addr
ret  in  1  pop return address, jump to it
jmp_addr  in  PC_WIDTH  target address from instruction decoder
pc  out  PC_WIDTH  registered address of instruction in execution
pm_address  out  PC_WIDTH  combinational next fetch address to program memory
sp  out  SP_WIDTH  number of valid stack entries
stack_overflow  out  1  sticky: call issued with stack full
stack_underflow  out  1  sticky: ret issued with stack empty

Behaviour:
- Reset (reset=0, asynchronous): pc=0, sp=0, all stack entries=0, both flags=0; pm_address forced to 0 combinationally. Reset must be held low for at least one full clk period so program memory latches address 0 on a falling edge.
- Each rising edge (reset=1): pc <= pm_address; stack/sp/flags updated per selected action.
- pm_address selection, strict priority (first match wins):
  1. hold=1 -> pc; no stack change.
  2. ret=1 -> if sp>0: stack[sp-1], sp decrements. If sp=0: pc+1 and stack_underflow set.
  3. call=1 -> jmp_addr. If sp<STACK_DEPTH: push pc+1, sp increments. If full: push discarded, stack_overflow set, jump still taken.
  4. jmp=1 -> jmp_addr.
  5. jmp_nz=1 and dont_jmp=0 -> jmp_addr.
  6. otherwise -> pc+1.
- Lower-priority requests asserted together with a higher one are ignored and have no side effect. Example: call+jmp behaves as call; hold+ret causes no pop.
- pc+1 wraps modulo 2^PC_WIDTH. A pushed return address of all-ones+1 is stored as 0.
- Stack is LIFO. Entry index = sp-1 for the top. Entries above sp are don't-care and are not observable.
- The pm_address path is purely combinational from pc, stack top, sp and the inputs. There is zero-cycle latency from request to address. The target instruction is in pc one rising edge later.
- stack_overflow and stack_underflow stay set until reset. They do not block further operation.
- When reset is asserted mid-call or mid-return, all state clears immediately. There is no partial push or pop.

Decomposition:
- Shared package micro_pkg: default PC_WIDTH, STACK_DEPTH, and localparam encodings for the next-address source select (SRC_HOLD, SRC_RET, SRC_CALL, SRC_JMP, SRC_INC). The decoder and the bench reuse these encodings.
- One sub-module: return_stack (push, pop, data_in, top, sp, full, empty, with the same async active-low reset). It holds all storage and pointer logic. The sequencer top holds the priority mux and pc register.

Test Plan:
- Reset then free-run: release reset, no requests -> pc steps 0,1,2,3 on successive edges; pm_address = pc+1; sp=0.
- Unconditional and conditional jump: at pc=5, jmp=1, jmp_addr=0x2A0 -> pc=0x2A0 next edge. At pc=0x2A3, jmp_nz=1 with dont_jmp=1 -> pc=0x2A4. Repeat with dont_jmp=0 -> pc=jmp_addr.
- Nested call/return: call at pc=0x010 to 0x100, then call at pc=0x102 to 0x200 -> sp=2. Two rets -> pc=0x103, then pc=0x011; sp=0; no flags set.
- Overflow/underflow (STACK_DEPTH=4): 5 calls -> sp=4, stack_overflow=1, 5th target still reached. 5 rets -> first four return the stacked addresses, 5th gives pc+1 with stack_underflow=1. Both flags stay high until reset.
- Hold and priority: hold with ret at sp=1 -> pc unchanged, sp=1. call+jmp same cycle -> call semantics, sp increments. PC wrap: at pc=0x3FF free-run gives pc=0x000.
- Async reset mid-stack: with sp=3, drive reset low between edges -> pc, pm_address, sp and flags go to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the micro core program sequencer: default sizes and
// next-address source encodings reused by the decoder and verification.
package micro_pkg;

    localparam int unsigned PC_WIDTH_DEF    = 10;
    localparam int unsigned STACK_DEPTH_DEF = 4;
    localparam int unsigned SP_WIDTH_DEF    = 3;

    localparam int unsigned SRC_WIDTH = 3;

    localparam logic [SRC_WIDTH-1:0] SRC_HOLD = 3'd0;
    localparam logic [SRC_WIDTH-1:0] SRC_RET  = 3'd1;
    localparam logic [SRC_WIDTH-1:0] SRC_CALL = 3'd2;
    localparam logic [SRC_WIDTH-1:0] SRC_JMP  = 3'd3;
    localparam logic [SRC_WIDTH-1:0] SRC_INC  = 3'd4;

endpackage

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses with occupancy count; entries above sp
// keep stale data that is never presented on top.
module return_stack #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned SP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    top,
    output logic [SP_WIDTH-1:0] sp,
    output logic                full,
    output logic                empty
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage and pointer; the caller never asserts push with full or pop with empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (sp == SP_WIDTH'(i)) begin
                    mem[i] <= data_in;
                end
            end
            sp <= sp + SP_WIDTH'(1);
        end else if (pop) begin
            sp <= sp - SP_WIDTH'(1);
        end
    end

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sp == SP_WIDTH'(i + 1)) begin
                top = mem[i];
            end
        end
    end

    assign full  = (sp == SP_WIDTH'(DEPTH));
    assign empty = (sp == '0);

endmodule

// File: rtl/stacked_program_sequencer.sv
// Program sequencer: priority next-address mux, pc register, call/return stack
// and sticky stack error flags.
module stacked_program_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int unsigned SP_WIDTH    = SP_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                jmp,
    input  logic                jmp_nz,
    input  logic                dont_jmp,
    input  logic                call,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pm_address,
    output logic [SP_WIDTH-1:0] sp,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    logic [SRC_WIDTH-1:0] src;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  next_addr;
    logic [PC_WIDTH-1:0]  stack_top;
    logic                 push;
    logic                 pop;
    logic                 set_ovf;
    logic                 set_unf;
    logic                 full;
    logic                 empty;

    assign pc_inc = pc + PC_WIDTH'(1);

    // Strict-priority request decode; only the winning request has side effects
    always_comb begin
        src     = SRC_INC;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (hold) begin
            src = SRC_HOLD;
        end else if (ret) begin
            if (empty) begin
                set_unf = 1'b1;
            end else begin
                src = SRC_RET;
                pop = 1'b1;
            end
        end else if (call) begin
            src = SRC_CALL;
            if (full) begin
                set_ovf = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            src = SRC_JMP;
        end
    end

    always_comb begin
        next_addr = pc_inc;
        case (src)
            SRC_HOLD: next_addr = pc;
            SRC_RET:  next_addr = stack_top;
            SRC_CALL: next_addr = jmp_addr;
            SRC_JMP:  next_addr = jmp_addr;
            default:  next_addr = pc_inc;
        endcase
    end

    // Address 0 is presented while reset is low so memory fetches the reset vector
    assign pm_address = reset ? next_addr : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            pc <= pm_address;
            if (set_ovf) begin
                stack_overflow <= 1'b1;
            end
            if (set_unf) begin
                stack_underflow <= 1'b1;
            end
        end
    end

    return_stack #(
        .DEPTH    (STACK_DEPTH),
        .WIDTH    (PC_WIDTH),
        .SP_WIDTH (SP_WIDTH)
    ) u_return_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (stack_top),
        .sp      (sp),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_stacked_program_sequencer.sv
// Directed self-checking bench for stacked_program_sequencer (default sizes).
module tb_stacked_program_sequencer;

    localparam int unsigned PW = 10;
    localparam int unsigned SW = 3;

    logic          clk;
    logic          reset;
    logic          hold;
    logic          jmp;
    logic          jmp_nz;
    logic          dont_jmp;
    logic          call;
    logic          ret;
    logic [PW-1:0] jmp_addr;
    logic [PW-1:0] pc;
    logic [PW-1:0] pm_address;
    logic [SW-1:0] sp;
    logic          stack_overflow;
    logic          stack_underflow;

    int checks = 0;
    int errors = 0;

    stacked_program_sequencer #(
        .PC_WIDTH    (10),
        .STACK_DEPTH (4),
        .SP_WIDTH    (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hold            (hold),
        .jmp             (jmp),
        .jmp_nz          (jmp_nz),
        .dont_jmp        (dont_jmp),
        .call            (call),
        .ret             (ret),
        .jmp_addr        (jmp_addr),
        .pc              (pc),
        .pm_address      (pm_address),
        .sp              (sp),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle(); jmp_addr = '0;
        step(); step();
        checks++;
        if (pc !== 10'h000 || sp !== 3'd0 || pm_address !== 10'h000) begin
            errors++;
            $display("FAIL reset_state pc=%h sp=%0d pm=%h want 000 0 000", pc, sp, pm_address);
        end
        checks++;
        if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ovf=%b unf=%b want 0 0", stack_overflow, stack_underflow);
        end
        reset = 1; #1;
        checks++;
        if (pm_address !== 10'h001) begin
            errors++;
            $display("FAIL reset_release_pm pm=%h want 001", pm_address);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pc !== PW'(i) || pm_address !== PW'(i + 1) || sp !== 3'd0) begin
                errors++;
                $display("FAIL free_run_%0d pc=%h pm=%h sp=%0d want %h %h 0",
                         i, pc, pm_address, sp, PW'(i), PW'(i + 1));
            end
        end
    endtask

    task automatic test_jumps();
        step(); step();
        checks++;
        if (pc !== 10'h005) begin
            errors++;
            $display("FAIL jmp_setup pc=%h want 005", pc);
        end
        jmp = 1; jmp_addr = 10'h2A0; #1;
        checks++;
        if (pm_address !== 10'h2A0) begin
            errors++;
            $display("FAIL jmp_comb pm=%h want 2a0", pm_address);
        end
        step(); idle();
        checks++;
        if (pc !== 10'h2A0) begin
            errors++;
            $display("FAIL jmp pc=%h want 2a0", pc);
        end
        step(); step(); step();
        jmp_nz = 1; dont_jmp = 1; jmp_addr = 10'h155;
        step();
        checks++;
        if (pc !== 10'h2A4) begin
            errors++;
            $display("FAIL jmp_nz_not_taken pc=%h want 2a4", pc);
        end
        dont_jmp = 0;
        step(); idle();
        checks++;
        if (pc !== 10'h155) begin
            errors++;
            $display("FAIL jmp_nz_taken pc=%h want 155", pc);
        end
    endtask

    task automatic test_nested_call();
        jmp = 1; jmp_addr = 10'h010; step(); idle();
        call = 1; jmp_addr = 10'h100; step(); idle();
        checks++;
        if (pc !== 10'h100 || sp !== 3'd1) begin
            errors++;
            $display("FAIL call1 pc=%h sp=%0d want 100 1", pc, sp);
        end
        step(); step();
        call = 1; jmp_addr = 10'h200; step(); idle();
        checks++;
        if (pc !== 10'h200 || sp !== 3'd2) begin
            errors++;
            $display("FAIL call2 pc=%h sp=%0d want 200 2", pc, sp);
        end
        ret = 1; #1;
        checks++;
        if (pm_address !== 10'h103) begin
            errors++;
            $display("FAIL ret1_comb pm=%h want 103", pm_address);
        end
        step();
        checks++;
        if (pc !== 10'h103 || sp !== 3'd1) begin
            errors++;
            $display("FAIL ret1 pc=%h sp=%0d want 103 1", pc, sp);
        end
        step(); idle();
        checks++;
        if (pc !== 10'h011 || sp !== 3'd0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            errors++;
            $display("FAIL ret2 pc=%h sp=%0d ovf=%b unf=%b want 011 0 0 0",
                     pc, sp, stack_overflow, stack_underflow);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [PW-1:0] rets [4];
        rets[0] = 10'h321; rets[1] = 10'h311; rets[2] = 10'h301; rets[3] = 10'h012;
        for (int i = 0; i < 5; i++) begin
            call = 1; jmp_addr = PW'(10'h300 + i * 16);
            step();
            checks++;
            if (pc !== PW'(10'h300 + i * 16) || sp !== SW'((i < 4) ? i + 1 : 4)
                || stack_overflow !== ((i == 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ovf_call_%0d pc=%h sp=%0d ovf=%b", i, pc, sp, stack_overflow);
            end
        end
        idle(); ret = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== rets[i] || sp !== SW'(3 - i)) begin
                errors++;
                $display("FAIL unf_ret_%0d pc=%h sp=%0d want %h %0d", i, pc, sp, rets[i], 3 - i);
            end
        end
        checks++;
        if (stack_underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_early unf=%b want 0", stack_underflow);
        end
        step(); idle();
        checks++;
        if (pc !== 10'h013 || sp !== 3'd0 || stack_underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_ret_4 pc=%h sp=%0d unf=%b want 013 0 1", pc, sp, stack_underflow);
        end
        step();
        checks++;
        if (pc !== 10'h014 || stack_overflow !== 1'b1 || stack_underflow !== 1'b1) begin
            errors++;
            $display("FAIL flags_sticky pc=%h ovf=%b unf=%b want 014 1 1",
                     pc, stack_overflow, stack_underflow);
        end
    endtask

    task automatic test_hold_priority();
        call = 1; jmp_addr = 10'h050; step(); idle();
        hold = 1; ret = 1; #1;
        checks++;
        if (pm_address !== 10'h050) begin
            errors++;
            $display("FAIL hold_comb pm=%h want 050", pm_address);
        end
        step(); idle();
        checks++;
        if (pc !== 10'h050 || sp !== 3'd1) begin
            errors++;
            $display("FAIL hold_ret pc=%h sp=%0d want 050 1", pc, sp);
        end
        call = 1; jmp = 1; jmp_addr = 10'h060; step(); idle();
        checks++;
        if (pc !== 10'h060 || sp !== 3'd2) begin
            errors++;
            $display("FAIL call_jmp pc=%h sp=%0d want 060 2", pc, sp);
        end
        ret = 1; step(); idle();
        checks++;
        if (pc !== 10'h051 || sp !== 3'd1) begin
            errors++;
            $display("FAIL call_jmp_ret pc=%h sp=%0d want 051 1", pc, sp);
        end
        jmp = 1; jmp_addr = 10'h3FF; step(); idle();
        step();
        checks++;
        if (pc !== 10'h000 || pm_address !== 10'h001) begin
            errors++;
            $display("FAIL pc_wrap pc=%h pm=%h want 000 001", pc, pm_address);
        end
        jmp = 1; jmp_addr = 10'h3FF; step(); idle();
        call = 1; jmp_addr = 10'h080; step(); idle();
        ret = 1; step(); idle();
        checks++;
        if (pc !== 10'h000 || sp !== 3'd1) begin
            errors++;
            $display("FAIL push_wrap pc=%h sp=%0d want 000 1", pc, sp);
        end
    endtask

    task automatic test_async_reset();
        call = 1; jmp_addr = 10'h070; step();
        call = 1; jmp_addr = 10'h078; step(); idle();
        checks++;
        if (sp !== 3'd3 || pc !== 10'h078) begin
            errors++;
            $display("FAIL areset_setup sp=%0d pc=%h want 3 078", sp, pc);
        end
        call = 1; jmp_addr = 10'h090;
        #2;
        reset = 0;
        #1;
        checks++;
        if (pc !== 10'h000 || pm_address !== 10'h000 || sp !== 3'd0) begin
            errors++;
            $display("FAIL areset_state pc=%h pm=%h sp=%0d want 000 000 0", pc, pm_address, sp);
        end
        checks++;
        if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_flags ovf=%b unf=%b want 0 0", stack_overflow, stack_underflow);
        end
        idle();
        step();
        reset = 1;
        ret = 1; step(); idle();
        checks++;
        if (pc !== 10'h001 || sp !== 3'd0 || stack_underflow !== 1'b1) begin
            errors++;
            $display("FAIL areset_after pc=%h sp=%0d unf=%b want 001 0 1", pc, sp, stack_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_jumps();
        test_nested_call();
        test_overflow_underflow();
        test_hold_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
